// File: rtl/tlb_mmu.sv
// MIPS32-style MMU: fully associative software-managed TLB plus CP0 regs.
// Optional PROBE (TLBP) support is compiled in when MMU_PROBE_EN is defined.
module tlb_mmu #(
    parameter int ENTRY_ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic        addrValid,
    input  logic [31:0] vAddr,
    output logic [31:0] pAddr,
    input  logic [1:0]  mmu_accessType,
    input  logic [2:0]  mmu_cmd,
    input  logic [2:0]  mmu_reg,
    input  logic [31:0] mmu_dataIn,
    output logic [31:0] mmu_dataOut,
    output logic [2:0]  mmu_exception
);

    localparam int W = ENTRY_ADDR_WIDTH;
    localparam int N = 1 << W;

    localparam logic [2:0] CMD_WREG  = 3'd1;
    localparam logic [2:0] CMD_WTLB  = 3'd2;
    localparam logic [2:0] CMD_RTLB  = 3'd3;
    localparam logic [2:0] CMD_PROBE = 3'd4;

    localparam logic [2:0] REG_INDEX = 3'd0;
    localparam logic [2:0] REG_LO0   = 3'd1;
    localparam logic [2:0] REG_LO1   = 3'd2;
    localparam logic [2:0] REG_MASK  = 3'd3;
    localparam logic [2:0] REG_HI    = 3'd4;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_MISS = 3'd1;
    localparam logic [2:0] EXC_TLBL = 3'd2;
    localparam logic [2:0] EXC_TLBS = 3'd3;
    localparam logic [2:0] EXC_MOD  = 3'd4;

    localparam logic [1:0] ACC_W = 2'd2;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [15:0] mask;
        logic        g;
        logic [25:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [25:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    logic          idx_p_q, idx_p_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [18:0]   vpn2_q, vpn2_d;
    logic [7:0]    asid_q, asid_d;
    logic [15:0]   mask_q, mask_d;
    logic [31:0]   lo0_q, lo0_d;
    logic [31:0]   lo1_q, lo1_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [2:0]    exc_q, exc_d;
    tlb_entry_t    tlb_q [N];
    tlb_entry_t    tlb_d [N];

    // Address match under the entry's page mask, honouring global pages
    function automatic logic ent_match(input tlb_entry_t e,
                                       input logic [18:0] vpn,
                                       input logic [7:0] asid);
        logic [18:0] m;
        m = ~{3'b000, e.mask};
        return ((vpn & m) == (e.vpn2 & m)) && (e.g || (e.asid == asid));
    endfunction

    logic          xl_hit;
    logic [W-1:0]  xl_idx;
    tlb_entry_t    xe;
    logic          xl_odd;
    logic [16:0]   odd_sel;
    logic [31:0]   off_m;
    logic [25:0]   xl_pfn;
    logic          xl_v;
    logic          xl_d;
    logic [31:0]   xl_pa;

    // Lookup for translation: descending scan so the lowest index wins
    always_comb begin
        xl_hit = 1'b0;
        xl_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_match(tlb_q[i], vAddr[31:13], asid_q)) begin
                xl_hit = 1'b1;
                xl_idx = W'(i);
            end
        end
    end

    // Even/odd half select and offset splice for the hit entry
    always_comb begin
        xe      = tlb_q[xl_idx];
        odd_sel = {1'b0, xe.mask} + 17'd1;
        xl_odd  = |(vAddr[28:12] & odd_sel);
        off_m   = {4'b0000, xe.mask, 12'hfff};
        xl_pfn  = xl_odd ? xe.pfn1 : xe.pfn0;
        xl_v    = xl_odd ? xe.v1 : xe.v0;
        xl_d    = xl_odd ? xe.d1 : xe.d0;
        xl_pa   = ({xl_pfn[19:0], 12'h000} & ~off_m) | (vAddr & off_m);
    end

`ifdef MMU_PROBE_EN
    logic          pr_hit;
    logic [W-1:0]  pr_idx;

    // Probe lookup keyed by EntryHi
    always_comb begin
        pr_hit = 1'b0;
        pr_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_match(tlb_q[i], vpn2_q, asid_q)) begin
                pr_hit = 1'b1;
                pr_idx = W'(i);
            end
        end
    end
`endif

    // Next state: command execution and translation result
    always_comb begin
        idx_p_d = idx_p_q;
        idx_d   = idx_q;
        vpn2_d  = vpn2_q;
        asid_d  = asid_q;
        mask_d  = mask_q;
        lo0_d   = lo0_q;
        lo1_d   = lo1_q;
        paddr_d = paddr_q;
        exc_d   = exc_q;
        tlb_d   = tlb_q;

        case (mmu_cmd)
            CMD_WREG: begin
                case (mmu_reg)
                    REG_INDEX: begin
                        idx_p_d = mmu_dataIn[31];
                        idx_d   = mmu_dataIn[W-1:0];
                    end
                    REG_LO0:  lo0_d = mmu_dataIn;
                    REG_LO1:  lo1_d = mmu_dataIn;
                    REG_MASK: mask_d = mmu_dataIn[28:13];
                    REG_HI: begin
                        vpn2_d = mmu_dataIn[31:13];
                        asid_d = mmu_dataIn[7:0];
                    end
                    default: ;
                endcase
            end
            CMD_WTLB: begin
                tlb_d[idx_q].vpn2 = vpn2_q;
                tlb_d[idx_q].asid = asid_q;
                tlb_d[idx_q].mask = mask_q;
                tlb_d[idx_q].g    = lo0_q[0] & lo1_q[0];
                tlb_d[idx_q].pfn0 = lo0_q[31:6];
                tlb_d[idx_q].c0   = lo0_q[5:3];
                tlb_d[idx_q].d0   = lo0_q[2];
                tlb_d[idx_q].v0   = lo0_q[1];
                tlb_d[idx_q].pfn1 = lo1_q[31:6];
                tlb_d[idx_q].c1   = lo1_q[5:3];
                tlb_d[idx_q].d1   = lo1_q[2];
                tlb_d[idx_q].v1   = lo1_q[1];
            end
            CMD_RTLB: begin
                vpn2_d = tlb_q[idx_q].vpn2;
                asid_d = tlb_q[idx_q].asid;
                mask_d = tlb_q[idx_q].mask;
                lo0_d  = {tlb_q[idx_q].pfn0, tlb_q[idx_q].c0,
                          tlb_q[idx_q].d0, tlb_q[idx_q].v0,
                          tlb_q[idx_q].g};
                lo1_d  = {tlb_q[idx_q].pfn1, tlb_q[idx_q].c1,
                          tlb_q[idx_q].d1, tlb_q[idx_q].v1,
                          tlb_q[idx_q].g};
            end
            CMD_PROBE: begin
`ifdef MMU_PROBE_EN
                if (pr_hit) begin
                    idx_p_d = 1'b0;
                    idx_d   = pr_idx;
                end else begin
                    idx_p_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase

        if (addrValid) begin
            if (vAddr[31:30] == 2'b10) begin
                paddr_d = {3'b000, vAddr[28:0]};
                exc_d   = EXC_NONE;
            end else if (!xl_hit) begin
                exc_d = EXC_MISS;
            end else if (!xl_v) begin
                exc_d = (mmu_accessType == ACC_W) ? EXC_TLBS : EXC_TLBL;
            end else if ((mmu_accessType == ACC_W) && !xl_d) begin
                exc_d = EXC_MOD;
            end else begin
                exc_d   = EXC_NONE;
                paddr_d = xl_pa;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            idx_p_q <= 1'b0;
            idx_q   <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            mask_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            paddr_q <= '0;
            exc_q   <= EXC_NONE;
            for (int i = 0; i < N; i++) begin
                tlb_q[i] <= '0;
            end
        end else begin
            idx_p_q <= idx_p_d;
            idx_q   <= idx_d;
            vpn2_q  <= vpn2_d;
            asid_q  <= asid_d;
            mask_q  <= mask_d;
            lo0_q   <= lo0_d;
            lo1_q   <= lo1_d;
            paddr_q <= paddr_d;
            exc_q   <= exc_d;
            for (int i = 0; i < N; i++) begin
                tlb_q[i] <= tlb_d[i];
            end
        end
    end

    // Combinational register read port
    always_comb begin
        mmu_dataOut = '0;
        case (mmu_reg)
            REG_INDEX: mmu_dataOut = {idx_p_q, {(31 - W){1'b0}}, idx_q};
            REG_LO0:   mmu_dataOut = lo0_q;
            REG_LO1:   mmu_dataOut = lo1_q;
            REG_MASK:  mmu_dataOut = {3'b000, mask_q, 13'h0000};
            REG_HI:    mmu_dataOut = {vpn2_q, 5'b00000, asid_q};
            default:   mmu_dataOut = '0;
        endcase
    end

    assign pAddr         = paddr_q;
    assign mmu_exception = exc_q;

endmodule

// File: tb/tb_tlb_mmu.sv
// Scoreboard bench for tlb_mmu: directed translations and register checks.
// Define MMU_PROBE_EN for both files to exercise the probe command.
module tb_tlb_mmu;

    logic        clk;
    logic        res;
    logic        addrValid;
    logic [31:0] vAddr;
    logic [31:0] pAddr;
    logic [1:0]  mmu_accessType;
    logic [2:0]  mmu_cmd;
    logic [2:0]  mmu_reg;
    logic [31:0] mmu_dataIn;
    logic [31:0] mmu_dataOut;
    logic [2:0]  mmu_exception;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] MISS = 3'd1;
    localparam logic [2:0] TLBL = 3'd2;
    localparam logic [2:0] TLBS = 3'd3;
    localparam logic [2:0] MOD  = 3'd4;

    typedef struct {
        logic [31:0] pa;
        logic [2:0]  ex;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic pend  = 1'b0;

    tlb_mmu #(.ENTRY_ADDR_WIDTH(3)) dut (
        .clk(clk),
        .res(res),
        .addrValid(addrValid),
        .vAddr(vAddr),
        .pAddr(pAddr),
        .mmu_accessType(mmu_accessType),
        .mmu_cmd(mmu_cmd),
        .mmu_reg(mmu_reg),
        .mmu_dataIn(mmu_dataIn),
        .mmu_dataOut(mmu_dataOut),
        .mmu_exception(mmu_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A translation was issued on this edge: result is due next negedge
    always @(posedge clk) pend <= addrValid && res;

    // Monitor: pop expected result and compare
    always @(negedge clk) begin
        if (pend) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: pAddr=%h exc=%0d, nothing expected",
                         pAddr, mmu_exception);
            end else begin
                e = exp_q.pop_front();
                if (pAddr !== e.pa || mmu_exception !== e.ex) begin
                    bad++;
                    $display("FAIL %s: pAddr=%h exc=%0d, expected pAddr=%h exc=%0d",
                             e.name, pAddr, mmu_exception, e.pa, e.ex);
                end
            end
        end
    end

    function automatic logic [31:0] lo(input int pfn, input bit d,
                                       input bit v, input bit g);
        return {pfn[25:0], 3'b000, d, v, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [2:0] r,
                          input logic [31:0] d);
        mmu_cmd    = c;
        mmu_reg    = r;
        mmu_dataIn = d;
        @(negedge clk);
        mmu_cmd = 3'd0;
    endtask

    task automatic wreg(input logic [2:0] r, input logic [31:0] d);
        do_cmd(3'd1, r, d);
    endtask

    task automatic rd_check(input string name, input logic [2:0] r,
                            input logic [31:0] expv);
        mmu_reg = r;
        #1;
        check(name, mmu_dataOut, expv);
    endtask

    task automatic write_entry(input int idx, input logic [31:0] hi,
                               input logic [31:0] mask,
                               input logic [31:0] l0,
                               input logic [31:0] l1);
        wreg(3'd0, idx);
        wreg(3'd4, hi);
        wreg(3'd3, mask);
        wreg(3'd1, l0);
        wreg(3'd2, l1);
        do_cmd(3'd2, 3'd0, 32'h0);
    endtask

    task automatic xlate(input string name, input logic [31:0] va,
                         input logic [1:0] at, input logic [31:0] pa,
                         input logic [2:0] ex);
        exp_t e;
        e.pa = pa;
        e.ex = ex;
        e.name = name;
        exp_q.push_back(e);
        vAddr          = va;
        mmu_accessType = at;
        addrValid      = 1'b1;
        @(negedge clk);
        addrValid = 1'b0;
    endtask

    initial begin
        exp_t e;
        res            = 1'b0;
        addrValid      = 1'b0;
        vAddr          = '0;
        mmu_accessType = 2'd0;
        mmu_cmd        = 3'd0;
        mmu_reg        = 3'd0;
        mmu_dataIn     = '0;

        #12;
        check("rst_paddr", pAddr, 32'h0);
        check("rst_exc", {29'd0, mmu_exception}, 32'h0);
        for (int r = 0; r < 5; r++) begin
            mmu_reg = 3'(r);
            #1;
            check($sformatf("rst_reg%0d", r), mmu_dataOut, 32'h0);
        end
        @(negedge clk);
        res = 1'b1;

        wreg(3'd4, 32'hFFFF_FFFF);
        rd_check("hi_reserved", 3'd4, 32'hFFFF_E0FF);
        wreg(3'd3, 32'hFFFF_FFFF);
        rd_check("mask_reserved", 3'd3, 32'h1FFF_E000);
        wreg(3'd0, 32'hFFFF_FFFF);
        rd_check("index_reserved", 3'd0, 32'h8000_0007);

        write_entry(1, {19'd2, 5'd0, 8'd1}, 32'h0, lo(20, 1, 1, 0), 32'h0);
        xlate("e1_load", 32'h0000_400C, 2'd1, 32'h0001_400C, NONE);

        write_entry(2, {19'd3, 5'd0, 8'd1}, 32'h0,
                    lo(70, 1, 1, 0), lo(80, 1, 1, 0));
        xlate("e2_even", 32'h0000_600E, 2'd1, 32'h0004_600E, NONE);
        xlate("e2_odd", 32'h0000_7013, 2'd1, 32'h0005_0013, NONE);

        xlate("kseg0", 32'h8123_4567, 2'd1, 32'h0123_4567, NONE);
        xlate("kseg1_store", 32'hA000_0010, 2'd2, 32'h0000_0010, NONE);

        write_entry(0, {19'd1, 5'd0, 8'd1}, 32'h0,
                    lo(5, 1, 1, 0), lo(6, 1, 0, 0));
        xlate("inv_store", 32'h0000_300C, 2'd2, 32'h0000_0010, TLBS);
        xlate("inv_load", 32'h0000_300C, 2'd1, 32'h0000_0010, TLBL);
        xlate("e0_even", 32'h0000_200C, 2'd1, 32'h0000_500C, NONE);

        write_entry(5, {19'd9, 5'd0, 8'd1}, 32'h0, lo(33, 0, 1, 0), 32'h0);
        xlate("mod_store", 32'h0001_2004, 2'd2, 32'h0000_500C, MOD);
        xlate("clean_load", 32'h0001_2004, 2'd1, 32'h0002_1004, NONE);
        xlate("acc_none", 32'h0001_2008, 2'd0, 32'h0002_1008, NONE);

        wreg(3'd4, 32'h0000_0002);
        xlate("asid_miss", 32'h0000_300C, 2'd1, 32'h0002_1008, MISS);

        write_entry(4, {17'd28, 2'b00, 5'd0, 8'd2}, 32'h0000_6000,
                    lo(2000, 1, 1, 0), lo(3000, 1, 1, 0));
        xlate("big_even", {17'd28, 1'b0, 14'd54}, 2'd1,
              {1'b0, 17'd500, 14'd54}, NONE);
        xlate("big_odd", {17'd28, 1'b1, 14'd54}, 2'd1,
              {1'b0, 17'd750, 14'd54}, NONE);

        write_entry(6, {19'd40, 5'd0, 8'd7}, 32'h0,
                    lo(9, 1, 1, 1), lo(9, 1, 1, 1));
        wreg(3'd4, 32'h0000_0002);
        xlate("global", 32'h0005_0010, 2'd1, 32'h0000_9010, NONE);
        write_entry(7, {19'd40, 5'd0, 8'd7}, 32'h0,
                    lo(11, 1, 1, 1), lo(11, 1, 1, 1));
        xlate("lowest_idx", 32'h0005_0010, 2'd1, 32'h0000_9010, NONE);

        wreg(3'd0, 32'd2);
        do_cmd(3'd3, 3'd0, 32'h0);
        rd_check("rd_hi", 3'd4, 32'h0000_6001);
        rd_check("rd_lo1", 3'd2, 32'h0000_1406);
        wreg(3'd0, 32'd6);
        do_cmd(3'd3, 3'd0, 32'h0);
        rd_check("rd_lo0_g", 3'd1, 32'h0000_0247);

        wreg(3'd4, 32'h0000_0002);
        mmu_cmd        = 3'd1;
        mmu_reg        = 3'd4;
        mmu_dataIn     = {19'd2, 5'd0, 8'd1};
        e.pa = 32'h0000_9010;
        e.ex = MISS;
        e.name = "same_edge";
        exp_q.push_back(e);
        vAddr          = 32'h0000_400C;
        mmu_accessType = 2'd1;
        addrValid      = 1'b1;
        @(negedge clk);
        mmu_cmd   = 3'd0;
        addrValid = 1'b0;
        xlate("after_edge", 32'h0000_400C, 2'd1, 32'h0001_400C, NONE);

        write_entry(3, {19'd77, 5'd0, 8'd2}, 32'h0, lo(1, 1, 1, 0), 32'h0);
        wreg(3'd0, 32'd0);
        do_cmd(3'd4, 3'd0, 32'h0);
`ifdef MMU_PROBE_EN
        rd_check("probe_hit", 3'd0, 32'h0000_0003);
`else
        rd_check("probe_hit", 3'd0, 32'h0000_0000);
`endif
        wreg(3'd4, {19'd99, 5'd0, 8'd2});
        wreg(3'd0, 32'd5);
        do_cmd(3'd4, 3'd0, 32'h0);
`ifdef MMU_PROBE_EN
        rd_check("probe_miss", 3'd0, 32'h8000_0005);
`else
        rd_check("probe_miss", 3'd0, 32'h0000_0005);
`endif

        @(negedge clk);
        #2;
        res = 1'b0;
        mmu_reg = 3'd0;
        #1;
        check("mid_rst_paddr", pAddr, 32'h0);
        check("mid_rst_exc", {29'd0, mmu_exception}, 32'h0);
        check("mid_rst_index", mmu_dataOut, 32'h0);
        @(negedge clk);
        res = 1'b1;
        wreg(3'd4, {19'd2, 5'd0, 8'd1});
        xlate("rst_miss", 32'h0000_400C, 2'd1, 32'h0000_0000, MISS);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_mmu.md
Name: tlb_mmu

Overview:
- MIPS32-style memory management unit.
- A fully associative, software-managed TLB translates virtual to physical addresses, plus a CP0-like register file: Index, EntryHi, PageMask, EntryLo0 and EntryLo1.
- Sits between the CPU address path and memory; the CPU's CP0/TLB instructions drive it through a command port.
- Translation result is registered, with one-cycle latency.

Parameters:
ENTRY_ADDR_WIDTH, 3, log2 of TLB entry count (default 8 entries).

Ports:
clk  in  1  clock, rising edge.
res  in  1  reset, asynchronous, active-low.
addrValid  in  1  translate vAddr on this edge.
vAddr  in  32  virtual address.
pAddr  out  32  translated physical address (registered).
mmu_accessType  in  2  0=NONE, 1=R (load/fetch), 2=W (store).
mmu_cmd  in  3  0=NONE, 1=WRITE_REG, 2=WRITE_TLB (TLBWI), 3=READ_TLB (TLBR), 4=PROBE (TLBP).
mmu_reg  in  3  register select: 0=INDEX, 1=ENTRYLO0, 2=ENTRYLO1, 3=PAGEMASK, 4=ENTRYHI.
mmu_dataIn  in  32  register write data.
mmu_dataOut  out  32  combinational read of the register selected by mmu_reg.
mmu_exception  out  3  0=NONE, 1=TLBMISS, 2=TLBL (invalid, load), 3=TLBS (invalid, store), 4=MOD (store to clean page); registered.

Behaviour:
- Register formats:
  - EntryHi = {VPN2[31:13], 5'b0, ASID[7:0]}.
  - PageMask = {3'b0, MASK[28:13], 13'b0}.
  - EntryLo = {PFN[31:6], C[5:3], D[2], V[1], G[0]}.
  - Index = {P[31], 0…, IDX[ENTRY_ADDR_WIDTH-1:0]}.
  - Reserved bits are written as 0 and read as 0.
- Reset (res=0, async):
  - All registers are cleared.
  - All TLB entries are cleared; V=0 in both halves.
  - pAddr=0, mmu_exception=NONE.
- Commands, sampled on the rising edge:
  - WRITE_REG: writes the register selected by mmu_reg.
  - WRITE_TLB: entry[Index.IDX] ← {EntryHi VPN2/ASID, MASK, Lo0, Lo1}. The entry's G = Lo0.G & Lo1.G.
  - READ_TLB: copies entry[Index.IDX] back into EntryHi, PageMask, Lo0 and Lo1. The G bit of both Lo halves is set from the entry's G.
  - NONE: no change. Encodings 5–7 also do nothing.
- Translation, on a rising edge with addrValid=1:
  - Unmapped window: if vAddr[31:30]==2'b10 (kseg0/kseg1), pAddr = {3'b000, vAddr[28:0]} and mmu_exception=NONE.
  - Otherwise the TLB is searched. An entry hits when (vAddr[31:13] & ~{3'b0,MASK}) == (VPN2 & ~{3'b0,MASK}) AND (G OR ASID == EntryHi.ASID).
  - If several entries hit, the lowest index wins.
  - Page size = 4KB << k, where MASK holds k low ones (k = 0, 2, 4 … 16).
  - The even/odd half is selected by vAddr[12+k]: 0 → Lo0, 1 → Lo1.
  - pAddr = ({PFN,12'b0} with bits [12+k-1:0] replaced by vAddr[12+k-1:0]), truncated to 32 bits.
- Exception priority:
  - No hit → TLBMISS.
  - Else V=0 → TLBS if accessType=W, otherwise TLBL.
  - Else accessType=W and D=0 → MOD.
  - Else NONE.
- On any exception, pAddr holds its previous value.
- addrValid=0: pAddr and mmu_exception hold their values.
- Command and translation on the same edge: the translation uses TLB and EntryHi contents from before the edge.
- An accessType of NONE or X on a valid page must not raise an exception.

Optional Feature:
- MMU_PROBE_EN defined: the PROBE command searches the TLB with EntryHi's VPN2/ASID under the entry masks and the same hit rules.
  - Hit: Index ← {1'b0, 0…, hit index}.
  - Miss: Index ← {1'b1, 0…}; IDX is unchanged.
- MMU_PROBE_EN not defined: PROBE behaves as NONE.

Test Plan:
- Entry 1 set to VPN2=2, ASID=1, Lo0 PFN=20, V=1; EntryHi ASID=1; load from 0x00004000+12 → pAddr=0x00014000+12, exception NONE.
- Entry 2 set to VPN2=3, Lo0 PFN=70, Lo1 PFN=80, both V=1; access 0x0000600E → 0x0004600E; access 0x00007013 → 0x00050013.
- vAddr=0x81234567 → pAddr=0x01234567 with no TLB lookup. Also 0xA0000010 → 0x00000010.
- Entry 0 set to VPN2=1 with Lo1 V=0; access 0x0000300C:
  - accessType W → TLBS.
  - accessType R → TLBL.
  - Write EntryHi=0x00000002 (ASID=2), then access again → TLBMISS.
- Entry 4 set to VPN2={17'd28,2'b0}, MASK=3, Lo0 PFN=2000; access {17'd28,1'b0,14'd54} → {1'b0,17'd500,14'd54}.
- Store to a valid page with D=0 → MOD, pAddr unchanged.
- Reset mid-sequence → all outputs zero/NONE, and previously valid pages now miss.
- Build with MMU_PROBE_EN:
  - PROBE with EntryHi matching entry 3 → Index=3.
  - PROBE with an unmatched VPN2 → Index[31]=1.
